// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer: retire-trace capture for the MIPS cores.
//
// The buffer records (pc, instruction, result) samples into a circular
// buffer of DEPTH entries. The newest entry overwrites the oldest.
// Capture stops in one of two ways:
//   - a PC-match trigger followed by POST_TRIG further samples
//   - a watchdog that fires CYC_LIMIT clocks after arm
// The captured history is then read out oldest-first. The read port is
// first-word-fall-through.
//
// Ports:
//   CLK, RST      clock; asynchronous active-high reset
//   arm           pulse: clear and start capture (honoured in IDLE/DONE)
//   smp_*         sample qualifier plus PC / instruction / result
//   trig_en/pc    PC-match trigger enable and address
//   rd_en         pop the head entry during readout
//   busy/done     capture in progress / capture finished
//   triggered     stop caused by the trigger window completing
//   timeout       stop caused by the watchdog
//   rd_valid/rd_* head entry of the readout; zero when rd_valid=0
//
// Optional feature, macro TRACE_CYCLE_STAMP_EN:
//   When this macro is defined, each entry also stores the cycle counter
//   value from the moment it was written. That value is presented on
//   rd_stamp.
module mips_trace_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    parameter int CYC_W     = 16,
    parameter int CYC_LIMIT = 1600
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              arm,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_pc,
    input  logic [DATA_W-1:0] smp_ins,
    input  logic [DATA_W-1:0] smp_result,
    input  logic              trig_en,
    input  logic [DATA_W-1:0] trig_pc,
    input  logic              rd_en,
    output logic              busy,
    output logic              done,
    output logic              triggered,
    output logic              timeout,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_pc,
    output logic [DATA_W-1:0] rd_ins,
    output logic [DATA_W-1:0] rd_result
`ifdef TRACE_CYCLE_STAMP_EN
    ,
    output logic [CYC_W-1:0]  rd_stamp
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int PST_W = (POST_TRIG < 2) ? 1 : $clog2(POST_TRIG + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [PST_W-1:0]   post_q, post_d;
    logic               trig_q, trig_d;
    logic               tmo_q, tmo_d;
    logic               wr_en;
    logic               post_end;

    logic [DATA_W-1:0]  pc_mem  [DEPTH];
    logic [DATA_W-1:0]  ins_mem [DEPTH];
    logic [DATA_W-1:0]  res_mem [DEPTH];
`ifdef TRACE_CYCLE_STAMP_EN
    logic [CYC_W-1:0]   stamp_mem [DEPTH];
`endif

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        remain_d = remain_q;
        cyc_d    = cyc_q;
        post_d   = post_q;
        trig_d   = trig_q;
        tmo_d    = tmo_q;
        wr_en    = 1'b0;
        post_end = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d  = S_ARMED;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                    remain_d = '0;
                    cyc_d    = '0;
                    post_d   = '0;
                    trig_d   = 1'b0;
                    tmo_d    = 1'b0;
                end else if (state_q == S_DONE && rd_en && remain_q != '0) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                end
            end

            S_ARMED, S_POST: begin
                cyc_d = cyc_q + 1'b1;
                if (smp_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (count_q != CNT_W'(DEPTH)) begin
                        count_d = count_q + 1'b1;
                    end
                end

                if (state_q == S_ARMED) begin
                    if (smp_valid && trig_en && smp_pc == trig_pc) begin
                        if (POST_TRIG == 0) begin
                            post_end = 1'b1;
                        end else begin
                            post_d  = PST_W'(POST_TRIG);
                            state_d = S_POST;
                        end
                    end
                end else if (smp_valid) begin
                    post_d   = post_q - 1'b1;
                    post_end = (post_q == PST_W'(1));
                end

                // Trigger completion takes precedence over the watchdog.
                if (post_end) begin
                    state_d = S_DONE;
                    trig_d  = 1'b1;
                end else if (cyc_d == CYC_W'(CYC_LIMIT)) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                end

                // Oldest surviving entry sits count entries behind the write pointer.
                if (state_d == S_DONE) begin
                    rd_ptr_d = wr_ptr_d - count_d[PTR_W-1:0];
                    remain_d = count_d;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            remain_q <= '0;
            cyc_q    <= '0;
            post_q   <= '0;
            trig_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            remain_q <= remain_d;
            cyc_q    <= cyc_d;
            post_q   <= post_d;
            trig_q   <= trig_d;
            tmo_q    <= tmo_d;
        end
    end

    // Storage is not reset; rd_valid gating keeps stale contents invisible.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            pc_mem[wr_ptr_q]    <= smp_pc;
            ins_mem[wr_ptr_q]   <= smp_ins;
            res_mem[wr_ptr_q]   <= smp_result;
`ifdef TRACE_CYCLE_STAMP_EN
            stamp_mem[wr_ptr_q] <= cyc_q;
`endif
        end
    end

    assign busy      = (state_q == S_ARMED) || (state_q == S_POST);
    assign done      = (state_q == S_DONE);
    assign triggered = trig_q;
    assign timeout   = tmo_q;
    assign rd_valid  = (state_q == S_DONE) && (remain_q != '0);
    assign rd_pc     = rd_valid ? pc_mem[rd_ptr_q]  : '0;
    assign rd_ins    = rd_valid ? ins_mem[rd_ptr_q] : '0;
    assign rd_result = rd_valid ? res_mem[rd_ptr_q] : '0;
`ifdef TRACE_CYCLE_STAMP_EN
    assign rd_stamp  = rd_valid ? stamp_mem[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Self-checking bench for mips_trace_buffer (DEPTH=8, POST_TRIG=2, CYC_LIMIT=100).
// The bench holds a queue-based model of the trace history. It checks every
// output on each cycle, and it also runs directed literal checks.
module tb_mips_trace_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int PT    = 2;
    localparam int CW    = 16;
    localparam int CL    = 100;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          arm = 1'b0;
    logic          smp_valid = 1'b0;
    logic [DW-1:0] smp_pc = '0;
    logic [DW-1:0] smp_ins = '0;
    logic [DW-1:0] smp_result = '0;
    logic          trig_en = 1'b0;
    logic [DW-1:0] trig_pc = '0;
    logic          rd_en = 1'b0;
    logic          busy, done, triggered, timeout, rd_valid;
    logic [DW-1:0] rd_pc, rd_ins, rd_result;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [CW-1:0] rd_stamp;
`endif

    mips_trace_buffer #(
        .DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(PT), .CYC_W(CW), .CYC_LIMIT(CL)
    ) dut (
        .CLK(CLK), .RST(RST), .arm(arm), .smp_valid(smp_valid),
        .smp_pc(smp_pc), .smp_ins(smp_ins), .smp_result(smp_result),
        .trig_en(trig_en), .trig_pc(trig_pc), .rd_en(rd_en),
        .busy(busy), .done(done), .triggered(triggered), .timeout(timeout),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_ins(rd_ins), .rd_result(rd_result)
`ifdef TRACE_CYCLE_STAMP_EN
        , .rd_stamp(rd_stamp)
`endif
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [DW-1:0] pc;
        logic [DW-1:0] ins;
        logic [DW-1:0] res;
        logic [CW-1:0] stamp;
    } ent_t;

    typedef enum {M_IDLE, M_ARMED, M_POST, M_DONE} mst_t;

    ent_t mq[$];
    mst_t m_st   = M_IDLE;
    int   m_cyc  = 0;
    int   m_post = 0;
    bit   m_trig = 1'b0;
    bit   m_tmo  = 1'b0;

    function automatic logic [DW-1:0] ins_of(input logic [DW-1:0] pc);
        return {pc[15:0], 16'hC0DE};
    endfunction

    function automatic logic [DW-1:0] res_of(input logic [DW-1:0] pc);
        return pc * 3 + 32'h11;
    endfunction

    task automatic model_step();
        mst_t st;
        bit   fin;
        ent_t e;
        st  = m_st;
        fin = 1'b0;
        if (st == M_IDLE || st == M_DONE) begin
            if (arm) begin
                mq.delete();
                m_cyc = 0; m_post = 0; m_trig = 1'b0; m_tmo = 1'b0;
                m_st = M_ARMED;
            end else if (st == M_DONE && rd_en && mq.size() > 0) begin
                void'(mq.pop_front());
            end
        end else begin
            if (smp_valid) begin
                e.pc = smp_pc; e.ins = smp_ins; e.res = smp_result; e.stamp = CW'(m_cyc);
                mq.push_back(e);
                if (mq.size() > DEPTH) void'(mq.pop_front());
            end
            m_cyc++;
            if (st == M_ARMED && smp_valid && trig_en && smp_pc == trig_pc) begin
                if (PT == 0) fin = 1'b1;
                else begin
                    m_post = PT;
                    m_st = M_POST;
                end
            end else if (st == M_POST && smp_valid) begin
                m_post--;
                if (m_post == 0) fin = 1'b1;
            end
            if (fin) begin
                m_st = M_DONE; m_trig = 1'b1;
            end else if (m_cyc == CL) begin
                m_st = M_DONE; m_tmo = 1'b1;
            end
        end
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mq.delete();
            m_st = M_IDLE; m_cyc = 0; m_post = 0; m_trig = 1'b0; m_tmo = 1'b0;
        end else begin
            model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        bit   ev;
        ent_t h;
        ev = (m_st == M_DONE) && (mq.size() > 0);
        if (ev) h = mq[0];
        else begin
            h.pc = '0; h.ins = '0; h.res = '0; h.stamp = '0;
        end
        chkb("busy", busy, (m_st == M_ARMED) || (m_st == M_POST));
        chkb("done", done, m_st == M_DONE);
        chkb("triggered", triggered, m_trig);
        chkb("timeout", timeout, m_tmo);
        chkb("rd_valid", rd_valid, ev);
        chk("rd_pc", rd_pc, h.pc);
        chk("rd_ins", rd_ins, h.ins);
        chk("rd_result", rd_result, h.res);
`ifdef TRACE_CYCLE_STAMP_EN
        chk("rd_stamp", DW'(rd_stamp), DW'(h.stamp));
`endif
    endtask

    always begin
        @(negedge CLK);
        #1;
        compare_all();
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input logic [DW-1:0] pc);
        @(negedge CLK);
        arm = 1'b0; rd_en = 1'b0;
        smp_valid = v; smp_pc = pc; smp_ins = ins_of(pc); smp_result = res_of(pc);
    endtask

    task automatic do_arm();
        @(negedge CLK);
        arm = 1'b1; smp_valid = 1'b0; rd_en = 1'b0;
        @(negedge CLK);
        arm = 1'b0;
    endtask

    task automatic settle();
        @(negedge CLK);
        smp_valid = 1'b0; arm = 1'b0; rd_en = 1'b0;
        #1;
    endtask

    // Checks the head PC, then pops it on the next clock.
    task automatic pop_chk(input string nm, input logic [DW-1:0] exp_pc);
        @(negedge CLK);
        smp_valid = 1'b0; rd_en = 1'b1;
        #1;
        chk(nm, rd_pc, exp_pc);
    endtask

    task automatic set_sample(input bit v, input logic [DW-1:0] pc);
        smp_valid = v; smp_pc = pc; smp_ins = ins_of(pc); smp_result = res_of(pc);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge CLK);
        #1;
        chkb("reset_busy", busy, 1'b0);
        chkb("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_rd_pc", rd_pc, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // T1: 11 samples, trigger 0x20, two post samples, wrap overwrites oldest
        trig_en = 1'b1; trig_pc = 32'h20;
        do_arm();
        for (int i = 0; i < 11; i++) drive(1'b1, DW'(i * 4));
        settle();
        chkb("t1_done", done, 1'b1);
        chkb("t1_triggered", triggered, 1'b1);
        chkb("t1_timeout", timeout, 1'b0);
        chk("t1_head_ins", rd_ins, 32'h000CC0DE);
        chk("t1_head_res", rd_result, 32'h00000035);
        for (int i = 0; i < 8; i++) pop_chk("t1_pop", DW'(32'h0C + i * 4));
        settle();
        chkb("t1_empty", rd_valid, 1'b0);

        // T2: trigger at 0x10, 7 entries total; arm from DONE
        trig_pc = 32'h10;
        do_arm();
        #1;
        chkb("t2_arm_busy", busy, 1'b1);
        for (int i = 0; i < 7; i++) drive(1'b1, DW'(i * 4));
        settle();
        chkb("t2_done", done, 1'b1);
        for (int i = 0; i < 7; i++) pop_chk("t2_pop", DW'(i * 4));
        settle();
        chkb("t2_empty", rd_valid, 1'b0);

        // T3: PC match without smp_valid is ignored; arm while busy is ignored
        trig_pc = 32'h20;
        do_arm();
        drive(1'b1, 32'h04);
        drive(1'b0, 32'h20);
        drive(1'b0, 32'h20);
        settle();
        chkb("t3_no_trig_busy", busy, 1'b1);
        chkb("t3_no_trig_done", done, 1'b0);
        drive(1'b1, 32'h20);
        do_arm();
        drive(1'b1, 32'h24);
        drive(1'b1, 32'h28);
        settle();
        chkb("t3_done", done, 1'b1);
        chkb("t3_triggered", triggered, 1'b1);
        pop_chk("t3_pop0", 32'h04);
        pop_chk("t3_pop1", 32'h20);
        settle();
        chkb("t3_left", rd_valid, 1'b1);

        // T4: watchdog; arm from DONE with entries left
        trig_pc = 32'hFFFF_FFF0;
        do_arm();
        #1;
        chkb("t4_arm_rd_valid", rd_valid, 1'b0);
        chkb("t4_arm_triggered", triggered, 1'b0);
        n = 0;
        while (!done && n < 200) begin
            set_sample(1'b1, DW'(n * 4));
            @(negedge CLK);
            #1;
            n++;
        end
        smp_valid = 1'b0;
        chk("t4_cycles", DW'(n), 32'd100);
        chkb("t4_timeout", timeout, 1'b1);
        chkb("t4_triggered", triggered, 1'b0);
        for (int i = 0; i < 8; i++) pop_chk("t4_pop", DW'(32'h170 + i * 4));
        settle();
        chkb("t4_empty", rd_valid, 1'b0);

        // T5: trigger window completes on the watchdog cycle; trigger wins
        trig_pc = 32'h30;
        do_arm();
        n = 0;
        while (!done && n < 200) begin
            set_sample((n + 1 >= 98) && (n + 1 <= 100), DW'(32'h30 + (n - 97) * 4));
            @(negedge CLK);
            #1;
            n++;
        end
        smp_valid = 1'b0;
        chk("t5_cycles", DW'(n), 32'd100);
        chkb("t5_triggered", triggered, 1'b1);
        chkb("t5_timeout", timeout, 1'b0);
        chk("t5_head", rd_pc, 32'h30);

        // T6: reset during POST, then during readout
        trig_pc = 32'h08;
        do_arm();
        drive(1'b1, 32'h00);
        drive(1'b1, 32'h04);
        drive(1'b1, 32'h08);
        @(negedge CLK);
        smp_valid = 1'b0; RST = 1'b1;
        #1;
        chkb("t6_rst_busy", busy, 1'b0);
        chkb("t6_rst_done", done, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        do_arm();
        for (int i = 0; i < 5; i++) drive(1'b1, DW'(i * 4));
        settle();
        chkb("t6_done", done, 1'b1);
        pop_chk("t6_pop0", 32'h00);
        pop_chk("t6_pop1", 32'h04);
        @(negedge CLK);
        rd_en = 1'b0; RST = 1'b1;
        #1;
        chkb("t6_rst2_rd_valid", rd_valid, 1'b0);
        chk("t6_rst2_rd_pc", rd_pc, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        trig_pc = 32'h44;
        do_arm();
        drive(1'b1, 32'h40);
        drive(1'b1, 32'h44);
        drive(1'b1, 32'h48);
        drive(1'b1, 32'h4C);
        settle();
        chkb("t6_recap_done", done, 1'b1);
        for (int i = 0; i < 4; i++) pop_chk("t6_recap_pop", DW'(32'h40 + i * 4));
        settle();
        chkb("t6_recap_empty", rd_valid, 1'b0);

        repeat (2) @(negedge CLK);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
